// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial transmitter: one WIDTH-bit frame per bit-counter wrap, IDLE preamble after reset.
// Optional even parity bit per frame when PS_PARITY_EN is defined.
module paralelo_serial_param #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = 8'hBC,
  parameter int             PREAMBLE  = 2,
  parameter int             LSB_FIRST = 0
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             active,
  output logic             data_out
);

`ifdef PS_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  localparam logic [3:0] PRE = 4'(PREAMBLE);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  localparam state_t RST_ST = (PREAMBLE == 0) ? ACTIVE : SYNC;

  state_t         state;
  logic [CW-1:0]  bit_cnt;
  logic [F-2:0]   shreg;
  logic [3:0]     pre_cnt;
  logic           load;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] ord;
  logic [F-1:0]   frame;

  assign load   = (bit_cnt == '0);
  assign active = (state == ACTIVE);
  assign ready  = (state == ACTIVE) && load;

  // ord[WIDTH-1] is always the first bit on the wire
  always_comb begin
    word = IDLE_WORD;
    if (state == ACTIVE && valid_in)
      word = data_in;
    ord = word;
    if (LSB_FIRST != 0)
      for (int i = 0; i < WIDTH; i++)
        ord[i] = word[WIDTH-1-i];
`ifdef PS_PARITY_EN
    frame = {ord, ^word};
`else
    frame = ord;
`endif
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= RST_ST;
      bit_cnt  <= '0;
      shreg    <= '0;
      pre_cnt  <= '0;
      data_out <= 1'b0;
    end else begin
      if (load) begin
        data_out <= frame[F-1];
        shreg    <= frame[F-2:0];
        bit_cnt  <= CW'(1);
        if (state == SYNC)
          pre_cnt <= pre_cnt + 4'd1;
      end else begin
        data_out <= shreg[F-2];
        shreg    <= shreg << 1;
        bit_cnt  <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      end
      // switch on the last bit of the final preamble word so ready leads the data load
      if (state == SYNC && bit_cnt == LAST && pre_cnt == PRE)
        state <= ACTIVE;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: directed table, random frames, mid-frame reset.
// Second instance covers LSB_FIRST=1 with PREAMBLE=0.
module tb_paralelo_serial_param;
  localparam int W = 8;
  localparam int P = 2;
`ifdef PS_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  localparam logic [7:0] IDLE = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_in_l = '0;
  logic       valid_in = 1'b0;
  logic       valid_in_l = 1'b0;
  logic       ready, active, data_out;
  logic       ready_l, active_l, data_out_l;

  int n_cmp = 0;
  int n_bad = 0;
  int fidx = 0;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_param #(
    .WIDTH(W), .IDLE_WORD(IDLE), .PREAMBLE(P), .LSB_FIRST(0)
  ) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .ready(ready), .active(active),
    .data_out(data_out)
  );

  paralelo_serial_param #(
    .WIDTH(W), .IDLE_WORD(IDLE), .PREAMBLE(0), .LSB_FIRST(1)
  ) dut_l (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in_l),
    .valid_in(valid_in_l), .ready(ready_l), .active(active_l),
    .data_out(data_out_l)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       vl;
    logic [7:0] dl;
    logic [7:0] ew;
    logic [7:0] ewl;
  } vec_t;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // bit k of the frame carrying word w, straight from the wire format
  function automatic logic exp_bit(logic [7:0] w, int k, bit lsb);
    if (k >= W) return ^w;
    return lsb ? w[k] : w[W-1-k];
  endfunction

  task automatic do_frame(input logic v, input logic [7:0] d,
                          input logic vl, input logic [7:0] dl,
                          input logic [7:0] ew, input logic [7:0] ewl);
    logic ea;
    valid_in = v;
    data_in = d;
    valid_in_l = vl;
    data_in_l = dl;
    for (int k = 0; k < F; k++) begin
      @(posedge clk_32f);
      #1;
      if (k == 0) begin
        data_in = 8'($urandom);
        valid_in = 1'($urandom);
        data_in_l = 8'($urandom);
        valid_in_l = 1'($urandom);
      end
      ea = (fidx >= P) || (fidx == P - 1 && k == F - 1);
      chk($sformatf("data_out f%0d b%0d", fidx, k), data_out, exp_bit(ew, k, 0));
      chk($sformatf("active f%0d b%0d", fidx, k), active, ea);
      chk($sformatf("ready f%0d b%0d", fidx, k), ready, ea && (k == F - 1));
      chk($sformatf("data_out_l f%0d b%0d", fidx, k), data_out_l, exp_bit(ewl, k, 1));
      chk($sformatf("ready_l f%0d b%0d", fidx, k), ready_l, k == F - 1);
      chk($sformatf("active_l f%0d b%0d", fidx, k), active_l, 1'b1);
    end
    fidx++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " data_out"}, data_out, 1'b0);
    chk({tag, " ready"}, ready, 1'b0);
    chk({tag, " active"}, active, 1'b0);
    chk({tag, " data_out_l"}, data_out_l, 1'b0);
    chk({tag, " ready_l"}, ready_l, 1'b1);
    chk({tag, " active_l"}, active_l, 1'b1);
  endtask

  vec_t tbl[6];

  initial begin
    logic       v, vl;
    logic [7:0] d, dl;

    tbl[0] = '{1'b1, 8'hFF, 1'b1, 8'h01, 8'hFF, 8'h01};
    tbl[1] = '{1'b1, 8'hEE, 1'b0, 8'h77, 8'hEE, IDLE};
    tbl[2] = '{1'b0, 8'h05, 1'b1, 8'h80, IDLE, 8'h80};
    tbl[3] = '{1'b1, 8'h00, 1'b1, 8'h3C, 8'h00, 8'h3C};
    tbl[4] = '{1'b0, 8'hA5, 1'b0, 8'h00, IDLE, IDLE};
    tbl[5] = '{1'b1, 8'h5A, 1'b1, 8'hFE, 8'h5A, 8'hFE};

    repeat (3) @(posedge clk_32f);
    #1;
    chk_reset("reset");

    @(negedge clk_32f);
    reset = 1'b1;
    fidx = 0;
    for (int i = 0; i < P; i++)
      do_frame(1'b1, 8'hFF, 1'b1, 8'h01, IDLE, 8'h01);
    foreach (tbl[i])
      do_frame(tbl[i].v, tbl[i].d, tbl[i].vl, tbl[i].dl, tbl[i].ew, tbl[i].ewl);

    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom);
      d = 8'($urandom);
      vl = 1'($urandom);
      dl = 8'($urandom);
      do_frame(v, d, vl, dl, v ? d : IDLE, vl ? dl : IDLE);
    end

    valid_in = 1'b1;
    data_in = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_32f);
      #1;
      chk($sformatf("midreset pre b%0d", k), data_out, exp_bit(8'hEE, k, 0));
    end
    reset = 1'b0;
    #1;
    chk_reset("midreset");

    @(negedge clk_32f);
    reset = 1'b1;
    fidx = 0;
    for (int i = 0; i < P; i++)
      do_frame(1'b1, 8'hEE, 1'b1, 8'h01, IDLE, 8'h01);
    do_frame(1'b1, 8'hEE, 1'b1, 8'h01, 8'hEE, 8'h01);
    do_frame(1'b1, 8'h01, 1'b1, 8'hEE, 8'h01, 8'hEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
